// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: the shadow-slot record kept for
// each in-flight instruction and the operand source codes.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wen;
        logic             load;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
    } scb_slot_t;

    // Operand source codes for the default two forwarding stages; deeper
    // configurations continue the numbering (k = stage k).
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // Build a shadow slot; an invalid slot is all zeros so that stale
    // fields can never produce a forward from a bubble.
    function automatic scb_slot_t make_slot(
        input logic             valid,
        input logic [REG_W-1:0] dest,
        input logic             wen,
        input logic             load,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             use_rs,
        input logic             use_rt
    );
        scb_slot_t s;
        s = '0;
        if (valid) begin
            s.valid  = 1'b1;
            s.dest   = dest;
            s.wen    = wen;
            s.load   = load;
            s.rs     = rs;
            s.rt     = rt;
            s.use_rs = use_rs;
            s.use_rt = use_rt;
        end
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against one shadow slot. STAGE is the
// forwarding stage the producer will occupy when the consumer is in EX.
module scb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGE  = 1,
    parameter int LD_FWD = 2,
    parameter int FW     = 2
) (
    input  scb_slot_t        slot,
    input  logic [REG_W-1:0] src,
    input  logic             src_used,
    output logic             hit,
    output logic             load_blocked,
    output logic [FW-1:0]    stage
);

    localparam logic TOO_EARLY = (STAGE < LD_FWD);

    // Register 0 never matches; a load is blocked until it reaches LD_FWD.
    always_comb begin
        hit          = src_used && slot.valid && slot.wen &&
                       (slot.dest == src) && (src != '0);
        load_blocked = hit && slot.load && TOO_EARLY;
        stage        = hit ? FW'(STAGE) : '0;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadow of in-flight destinations from EX through
// NFWD forwarding stages, driving forwarding selects, load-use stalls,
// redirect flushes, memory-wait freezes and stall/flush counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NFWD   = 2,
    parameter int LD_FWD = 2,
    parameter int CNTW   = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        id_valid,
    input  logic [4:0]                  id_rs,
    input  logic [4:0]                  id_rt,
    input  logic                        id_use_rs,
    input  logic                        id_use_rt,
    input  logic [4:0]                  id_dest,
    input  logic                        id_wen,
    input  logic                        id_load,
    input  logic                        redirect,
    input  logic                        mem_wait,
    output logic                        pc_stall,
    output logic                        fd_stall,
    output logic                        fd_flush,
    output logic                        de_flush,
    output logic                        freeze,
    output logic [$clog2(NFWD+1)-1:0]   fwd_a,
    output logic [$clog2(NFWD+1)-1:0]   fwd_b,
    output logic [CNTW-1:0]             stall_cnt,
    output logic [CNTW-1:0]             flush_cnt
);

    localparam int FW = $clog2(NFWD+1);

    scb_slot_t       slots [0:NFWD];
    scb_slot_t       id_slot;
    logic            load_use;

    // Load-use checks: decode sources against slots 0..NFWD-1.
    logic [NFWD-1:0] blk_rs, blk_rt;
    logic [NFWD-1:0] unused_hit_rs, unused_hit_rt;
    logic [FW-1:0]   unused_stg_rs [0:NFWD-1];
    logic [FW-1:0]   unused_stg_rt [0:NFWD-1];

    // Forwarding checks: EX sources against slots 1..NFWD.
    logic [NFWD:1]   hit_a, hit_b, blk_a, blk_b;
    logic [FW-1:0]   stg_a [1:NFWD];
    logic [FW-1:0]   stg_b [1:NFWD];

    for (genvar j = 0; j < NFWD; j++) begin : g_ld
        scb_match #(.STAGE(j + 1), .LD_FWD(LD_FWD), .FW(FW)) u_rs (
            .slot(slots[j]), .src(id_rs), .src_used(id_valid && id_use_rs),
            .hit(unused_hit_rs[j]), .load_blocked(blk_rs[j]), .stage(unused_stg_rs[j])
        );
        scb_match #(.STAGE(j + 1), .LD_FWD(LD_FWD), .FW(FW)) u_rt (
            .slot(slots[j]), .src(id_rt), .src_used(id_valid && id_use_rt),
            .hit(unused_hit_rt[j]), .load_blocked(blk_rt[j]), .stage(unused_stg_rt[j])
        );
    end

    for (genvar k = 1; k <= NFWD; k++) begin : g_fwd
        scb_match #(.STAGE(k), .LD_FWD(LD_FWD), .FW(FW)) u_a (
            .slot(slots[k]), .src(slots[0].rs),
            .src_used(slots[0].valid && slots[0].use_rs),
            .hit(hit_a[k]), .load_blocked(blk_a[k]), .stage(stg_a[k])
        );
        scb_match #(.STAGE(k), .LD_FWD(LD_FWD), .FW(FW)) u_b (
            .slot(slots[k]), .src(slots[0].rt),
            .src_used(slots[0].valid && slots[0].use_rt),
            .hit(hit_b[k]), .load_blocked(blk_b[k]), .stage(stg_b[k])
        );
    end

    assign load_use = (|blk_rs) || (|blk_rt);

    // Pipeline control with priority mem_wait > redirect > load-use.
    always_comb begin
        freeze   = 1'b0;
        pc_stall = 1'b0;
        fd_stall = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        if (mem_wait) begin
            freeze   = 1'b1;
            pc_stall = 1'b1;
            fd_stall = 1'b1;
        end else if (redirect) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (load_use) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
        end
    end

    // Youngest matching producer wins; a too-early load falls back to the RF.
    always_comb begin
        fwd_a = FW'(FWD_RF);
        fwd_b = FW'(FWD_RF);
        for (int k = NFWD; k >= 1; k--) begin
            if (hit_a[k]) fwd_a = blk_a[k] ? FW'(FWD_RF) : stg_a[k];
            if (hit_b[k]) fwd_b = blk_b[k] ? FW'(FWD_RF) : stg_b[k];
        end
    end

    // Next EX entry; a flush of ID/EX loads a bubble.
    always_comb begin
        id_slot = make_slot(id_valid && !de_flush, id_dest, id_wen, id_load,
                            id_rs, id_rt, id_use_rs, id_use_rt);
    end

    // Shadow shift (held during freeze) and free-running perf counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k <= NFWD; k++) slots[k] <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!freeze) begin
                slots[0] <= id_slot;
                for (int k = 1; k <= NFWD; k++) slots[k] <= slots[k-1];
            end
            stall_cnt <= stall_cnt + CNTW'(pc_stall);
            flush_cnt <= flush_cnt + CNTW'(fd_flush);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance (NFWD=2, LD_FWD=2) and a
// deeper one (NFWD=3, LD_FWD=3, 4-bit counters) share one stimulus stream.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid, id_use_rs, id_use_rt, id_wen, id_load;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       redirect, mem_wait;

    logic        d2_pc_stall, d2_fd_stall, d2_fd_flush, d2_de_flush, d2_freeze;
    logic [1:0]  d2_fwd_a, d2_fwd_b;
    logic [31:0] d2_stall_cnt, d2_flush_cnt;
    logic        d3_pc_stall, d3_fd_stall, d3_fd_flush, d3_de_flush, d3_freeze;
    logic [1:0]  d3_fwd_a, d3_fwd_b;
    logic [3:0]  d3_stall_cnt, d3_flush_cnt;
    logic [8:0]  d2_vec, d3_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign d2_vec = {d2_pc_stall, d2_fd_stall, d2_fd_flush, d2_de_flush, d2_freeze, d2_fwd_a, d2_fwd_b};
    assign d3_vec = {d3_pc_stall, d3_fd_stall, d3_fd_flush, d3_de_flush, d3_freeze, d3_fwd_a, d3_fwd_b};

    hazard_scoreboard dut (
        .CLK(clk), .nRST(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wen(id_wen),
        .id_load(id_load), .redirect(redirect), .mem_wait(mem_wait),
        .pc_stall(d2_pc_stall), .fd_stall(d2_fd_stall), .fd_flush(d2_fd_flush),
        .de_flush(d2_de_flush), .freeze(d2_freeze), .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    hazard_scoreboard #(.NFWD(3), .LD_FWD(3), .CNTW(4)) dut3 (
        .CLK(clk), .nRST(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wen(id_wen),
        .id_load(id_load), .redirect(redirect), .mem_wait(mem_wait),
        .pc_stall(d3_pc_stall), .fd_stall(d3_fd_stall), .fd_flush(d3_fd_flush),
        .de_flush(d3_de_flush), .freeze(d3_freeze), .fwd_a(d3_fwd_a), .fwd_b(d3_fwd_b),
        .stall_cnt(d3_stall_cnt), .flush_cnt(d3_flush_cnt)
    );

    // ---------------- reference model ----------------
    // h[0] is the instruction now in EX, h[n] the one n stages older.
    typedef struct packed {
        logic       v;
        logic [4:0] d;
        logic       w;
        logic       ld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
    } ins_t;

    ins_t        h2[$];
    ins_t        h3[$];
    int unsigned m_stall2, m_flush2, m_stall3, m_flush3;

    function automatic bit m_match(input ins_t e, input logic [4:0] r);
        return e.v && e.w && (e.d == r) && (r != 5'd0);
    endfunction

    // Decode instruction needs a load result that will not be forwardable in time.
    function automatic bit m_load_use(input ins_t h[$], input int nfwd, input int ldf);
        bit hit;
        hit = 1'b0;
        if (!id_valid) return 1'b0;
        for (int j = 0; j < nfwd; j++)
            if (h[j].ld && (j + 1 < ldf) &&
                ((id_use_rs && m_match(h[j], id_rs)) || (id_use_rt && m_match(h[j], id_rt))))
                hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [1:0] m_fwd(input ins_t h[$], input int nfwd, input int ldf, input bit opb);
        logic [4:0] src;
        bit         used;
        src  = opb ? h[0].rt : h[0].rs;
        used = opb ? h[0].urt : h[0].urs;
        if (!h[0].v || !used) return 2'd0;
        for (int k = 1; k <= nfwd; k++)
            if (m_match(h[k], src)) return (h[k].ld && k < ldf) ? 2'd0 : 2'(k);
        return 2'd0;
    endfunction

    // {pc_stall, fd_stall, fd_flush, de_flush, freeze}
    function automatic logic [4:0] m_ctrl(input bit lu);
        if (mem_wait) return 5'b11001;
        if (redirect) return 5'b00110;
        if (lu)       return 5'b11010;
        return 5'b00000;
    endfunction

    function automatic ins_t m_entry(input bit bubble);
        ins_t e;
        e = '0;
        if (id_valid && !bubble) begin
            e.v = 1'b1; e.d = id_dest; e.w = id_wen; e.ld = id_load;
            e.rs = id_rs; e.rt = id_rt; e.urs = id_use_rs; e.urt = id_use_rt;
        end
        return e;
    endfunction

    task automatic model_clear();
        h2.delete();
        h3.delete();
        for (int i = 0; i < 3; i++) h2.push_back('0);
        for (int i = 0; i < 4; i++) h3.push_back('0);
        m_stall2 = 0; m_flush2 = 0; m_stall3 = 0; m_flush3 = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ins(input logic v, input logic [4:0] rs, input logic urs,
                           input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                           input logic wen, input logic ld);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_dest = dest; id_wen = wen; id_load = ld;
    endtask

    task automatic nop();
        set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock edge, moving the model with the same inputs.
    task automatic commit();
        logic [4:0] c2, c3;
        c2 = m_ctrl(m_load_use(h2, 2, 2));
        c3 = m_ctrl(m_load_use(h3, 3, 3));
        @(posedge clk);
        m_stall2 += 32'(c2[4]); m_flush2 += 32'(c2[2]);
        m_stall3 += 32'(c3[4]); m_flush3 += 32'(c3[2]);
        if (!mem_wait) begin
            h2.push_front(m_entry(c2[1])); void'(h2.pop_back());
            h3.push_front(m_entry(c3[1])); void'(h3.pop_back());
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; nop(); redirect = 1'b0; mem_wait = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; nop(); redirect = 1'b0; mem_wait = 1'b0;
        model_clear();
        #2;
        checks++; if (d2_vec !== 9'd0) begin errors++; $display("FAIL reset_out_d2 got=%b exp=0", d2_vec); end
        checks++; if (d3_vec !== 9'd0) begin errors++; $display("FAIL reset_out_d3 got=%b exp=0", d3_vec); end
        checks++; if (d2_stall_cnt !== 32'd0 || d2_flush_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", d2_stall_cnt, d2_flush_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (d2_vec !== 9'd0) begin errors++; $display("FAIL reset_idle got=%b exp=0", d2_vec); end
        commit();
    endtask

    task automatic test_load_use();
        do_reset();
        set_ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);     // LW $2,0($1)
        @(negedge clk);
        checks++; if (d2_pc_stall !== 1'b0) begin errors++; $display("FAIL lu_first got=%b exp=0", d2_pc_stall); end
        commit();
        set_ins(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);     // ADD $3,$2,$4
        @(negedge clk);
        checks++; if (d2_vec[8:4] !== 5'b11010) begin errors++; $display("FAIL lu_stall_d2 got=%b exp=11010", d2_vec[8:4]); end
        checks++; if (d3_vec[8:4] !== 5'b11010) begin errors++; $display("FAIL lu_stall_d3 got=%b exp=11010", d3_vec[8:4]); end
        commit();
        @(negedge clk);
        checks++; if (d2_pc_stall !== 1'b0) begin errors++; $display("FAIL lu_release_d2 got=%b exp=0", d2_pc_stall); end
        checks++; if (d3_pc_stall !== 1'b1) begin errors++; $display("FAIL lu_stall2_d3 got=%b exp=1", d3_pc_stall); end
        commit();
        @(negedge clk);
        checks++; if (d2_fwd_a !== 2'd2 || d2_fwd_b !== 2'd0) begin errors++;
            $display("FAIL lu_fwd_d2 got=%0d/%0d exp=2/0", d2_fwd_a, d2_fwd_b); end
        checks++; if (d2_stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_d2 got=%0d exp=1", d2_stall_cnt); end
        checks++; if (d3_pc_stall !== 1'b0) begin errors++; $display("FAIL lu_release_d3 got=%b exp=0", d3_pc_stall); end
        commit();
        nop();
        @(negedge clk);
        checks++; if (d3_fwd_a !== 2'd3) begin errors++; $display("FAIL lu_fwd_d3 got=%0d exp=3", d3_fwd_a); end
        checks++; if (d3_stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_cnt_d3 got=%0d exp=2", d3_stall_cnt); end
        commit();
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_ins(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);     // ADD $5,$1,$1
        commit();
        set_ins(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);     // SUB $6,$5,$5
        @(negedge clk);
        checks++; if (d2_vec[8:4] !== 5'b00000) begin errors++; $display("FAIL alu_nostall got=%b exp=00000", d2_vec[8:4]); end
        commit();
        nop();
        @(negedge clk);
        checks++; if (d2_fwd_a !== 2'd1 || d2_fwd_b !== 2'd1) begin errors++;
            $display("FAIL alu_fwd1 got=%0d/%0d exp=1/1", d2_fwd_a, d2_fwd_b); end
        commit();
        set_ins(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        commit();
        nop();
        commit();
        set_ins(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        commit();
        nop();
        @(negedge clk);
        checks++; if (d2_fwd_a !== 2'd2 || d2_fwd_b !== 2'd2) begin errors++;
            $display("FAIL alu_fwd2 got=%0d/%0d exp=2/2", d2_fwd_a, d2_fwd_b); end
        commit();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);     // LW $0,0($1)
        commit();
        set_ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);     // ADD $7,$0,$0
        @(negedge clk);
        checks++; if (d2_pc_stall !== 1'b0 || d3_pc_stall !== 1'b0) begin errors++;
            $display("FAIL zero_stall got=%b/%b exp=0/0", d2_pc_stall, d3_pc_stall); end
        commit();
        nop();
        @(negedge clk);
        checks++; if (d2_fwd_a !== 2'd0 || d2_fwd_b !== 2'd0) begin errors++;
            $display("FAIL zero_fwd got=%0d/%0d exp=0/0", d2_fwd_a, d2_fwd_b); end
        commit();
    endtask

    task automatic test_redirect();
        do_reset();
        set_ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);     // LW $2
        commit();
        set_ins(1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);     // BEQ $2,$0
        redirect = 1'b1;
        @(negedge clk);
        checks++; if (d2_vec[8:4] !== 5'b00110) begin errors++; $display("FAIL redir_d2 got=%b exp=00110", d2_vec[8:4]); end
        checks++; if (d3_vec[8:4] !== 5'b00110) begin errors++; $display("FAIL redir_d3 got=%b exp=00110", d3_vec[8:4]); end
        commit();
        redirect = 1'b0; nop();
        @(negedge clk);
        checks++; if (d2_flush_cnt !== 32'd1 || d2_stall_cnt !== 32'd0) begin errors++;
            $display("FAIL redir_cnt got=%0d/%0d exp=1/0", d2_flush_cnt, d2_stall_cnt); end
        commit();
    endtask

    task automatic test_freeze();
        do_reset();
        set_ins(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);     // ADD $5,$1,$1
        commit();
        set_ins(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);     // ADD $6,$5,$5
        commit();
        set_ins(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);     // ADD $7,$6,$5
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect = (i == 1);
            @(negedge clk);
            checks++; if (d2_vec !== 9'b11001_01_01) begin errors++;
                $display("FAIL freeze_c%0d got=%b exp=110010101", i, d2_vec); end
            commit();
        end
        mem_wait = 1'b0; redirect = 1'b0;
        @(negedge clk);
        checks++; if (d2_vec !== 9'b00000_01_01) begin errors++; $display("FAIL freeze_rel got=%b exp=000000101", d2_vec); end
        commit();
        nop();
        @(negedge clk);
        checks++; if (d2_fwd_a !== 2'd1 || d2_fwd_b !== 2'd2) begin errors++;
            $display("FAIL freeze_fwd got=%0d/%0d exp=1/2", d2_fwd_a, d2_fwd_b); end
        checks++; if (d2_stall_cnt !== 32'd3 || d2_flush_cnt !== 32'd0) begin errors++;
            $display("FAIL freeze_cnt got=%0d/%0d exp=3/0", d2_stall_cnt, d2_flush_cnt); end
        commit();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);     // LW $2
        commit();
        set_ins(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);     // ADD $3,$2,$4
        commit();
        @(negedge clk);
        checks++; if (d3_pc_stall !== 1'b1) begin errors++; $display("FAIL rst_pre got=%b exp=1", d3_pc_stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (d3_vec !== 9'd0) begin errors++; $display("FAIL rst_mid_out got=%b exp=0", d3_vec); end
        checks++; if (d3_stall_cnt !== 4'd0 || d2_stall_cnt !== 32'd0) begin errors++;
            $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", d3_stall_cnt, d2_stall_cnt); end
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1; nop();
    endtask

    task automatic test_random();
        logic [8:0] e2, e3;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_ins($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 9) == 0);
            mem_wait = ($urandom_range(0, 6) == 0);
            @(negedge clk);
            e2 = {m_ctrl(m_load_use(h2, 2, 2)), m_fwd(h2, 2, 2, 1'b0), m_fwd(h2, 2, 2, 1'b1)};
            e3 = {m_ctrl(m_load_use(h3, 3, 3)), m_fwd(h3, 3, 3, 1'b0), m_fwd(h3, 3, 3, 1'b1)};
            checks++; if (d2_vec !== e2) begin errors++; $display("FAIL rnd_out_d2 cyc=%0d got=%b exp=%b", i, d2_vec, e2); end
            checks++; if (d3_vec !== e3) begin errors++; $display("FAIL rnd_out_d3 cyc=%0d got=%b exp=%b", i, d3_vec, e3); end
            checks++; if (d2_stall_cnt !== m_stall2 || d2_flush_cnt !== m_flush2) begin errors++;
                $display("FAIL rnd_cnt_d2 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, d2_stall_cnt, d2_flush_cnt, m_stall2, m_flush2); end
            checks++; if (d3_stall_cnt !== 4'(m_stall3) || d3_flush_cnt !== 4'(m_flush3)) begin errors++;
                $display("FAIL rnd_cnt_d3 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, d3_stall_cnt, d3_flush_cnt, 4'(m_stall3), 4'(m_flush3)); end
            commit();
        end
        redirect = 1'b0; mem_wait = 1'b0; nop();
    endtask

    initial begin
        nop(); redirect = 1'b0; mem_wait = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_zero_reg();
        test_redirect();
        test_freeze();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
